// File: rtl/latch_write_arbiter_if.sv
// Requester/latch-side bus of the latch write arbiter.
// The slave modport is the arbiter's view; master is the requester/latch side.
interface latch_write_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       _req;
  logic [WIDTH-1:0] _wdata0;
  logic [WIDTH-1:0] _wdata1;
  logic [WIDTH-1:0] _wdata2;
  logic [WIDTH-1:0] _wdata3;
  logic [3:0]       _gnt;
  logic [3:0]       _ack;
  logic [WIDTH-1:0] _D;
  logic [WIDTH-1:0] _E;
  logic             _busy;
  logic [WIDTH-1:0] _return;

  modport master (
    output _req, _wdata0, _wdata1, _wdata2, _wdata3,
    input  _gnt, _ack, _D, _E, _busy, _return
  );

  modport slave (
    input  _req, _wdata0, _wdata1, _wdata2, _wdata3,
    output _gnt, _ack, _D, _E, _busy, _return
  );
endinterface

// File: rtl/latch_write_arbiter.sv
// Round-robin write controller for a shared enable latch.
// Grants one of four requesters, then walks the latch pins through
// setup (_E low, _D stable), a one-cycle enable, and hold (_E low, _D stable).
// Every output comes straight from a flop.
module latch_write_arbiter #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1
) (
  input logic                   _clock,
  input logic                   _reset,
  latch_write_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ENABLE,
    ST_HOLD
  } state_t;

  // Terminal count of the setup and hold phases.
  localparam logic [3:0] LAST_CNT = 4'(SETUP_CYC - 1);

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [1:0]       owner_reg, owner_next;
  logic [3:0]       gnt_reg, gnt_next;
  logic [3:0]       ack_reg, ack_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [WIDTH-1:0] e_reg, e_next;
  logic             busy_reg, busy_next;
  logic [WIDTH-1:0] return_reg, return_next;

  logic [WIDTH-1:0] wdata_arr [4];
  logic [3:0]       req_rot;
  logic [1:0]       win_off;
  logic [1:0]       winner;

  assign wdata_arr[0] = bus._wdata0;
  assign wdata_arr[1] = bus._wdata1;
  assign wdata_arr[2] = bus._wdata2;
  assign wdata_arr[3] = bus._wdata3;

  // Rotate the request vector so that bit 0 is the requester at ptr.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    logic [1:0] rot_idx;
    assign rot_idx     = ptr_reg + 2'(gi);
    assign req_rot[gi] = bus._req[rot_idx];
  end

  // First set bit of the rotated vector gives the offset of the winner from ptr.
  always_comb begin
    win_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_off = 2'(i);
      end
    end
  end

  assign winner = ptr_reg + win_off;

  // Next-state logic; output registers are loaded from the next state so
  // nothing combinational reaches the pins.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    ptr_next    = ptr_reg;
    owner_next  = owner_reg;
    gnt_next    = gnt_reg;
    d_next      = d_reg;
    return_next = return_reg;

    case (state_reg)
      ST_IDLE: begin
        // Requests are only looked at here; a busy arbiter ignores them.
        if (|bus._req) begin
          owner_next = winner;
          gnt_next   = 4'b0001 << winner;
          d_next     = wdata_arr[winner];
          cnt_next   = 4'd0;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = 4'd0;
          state_next = ST_ENABLE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      ST_ENABLE: begin
        return_next = d_reg;
        cnt_next    = 4'd0;
        state_next  = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_reg == LAST_CNT) begin
          gnt_next   = 4'b0000;
          ptr_next   = owner_reg + 2'd1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    e_next    = {WIDTH{state_next == ST_ENABLE}};
    busy_next = (state_next != ST_IDLE);
    ack_next  = (state_next == ST_HOLD && cnt_next == LAST_CNT) ? gnt_next : 4'b0000;
  end

  // State and output registers; reset drops _E at once and aborts any write.
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= 4'd0;
      ptr_reg    <= 2'd0;
      owner_reg  <= 2'd0;
      gnt_reg    <= 4'b0000;
      ack_reg    <= 4'b0000;
      d_reg      <= '0;
      e_reg      <= '0;
      busy_reg   <= 1'b0;
      return_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      ptr_reg    <= ptr_next;
      owner_reg  <= owner_next;
      gnt_reg    <= gnt_next;
      ack_reg    <= ack_next;
      d_reg      <= d_next;
      e_reg      <= e_next;
      busy_reg   <= busy_next;
      return_reg <= return_next;
    end
  end

  assign bus._gnt    = gnt_reg;
  assign bus._ack    = ack_reg;
  assign bus._D      = d_reg;
  assign bus._E      = e_reg;
  assign bus._busy   = busy_reg;
  assign bus._return = return_reg;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: one instance with a 1-cycle setup/hold and
// one with a 3-cycle setup/hold, each against a timeline reference model.
module tb_latch_write_arbiter;

  logic       clk;
  logic       rst_n [2];
  logic [3:0] req_v [2];
  logic [7:0] wd_v  [2][4];

  latch_write_arbiter_if #(.WIDTH(8)) bus0 ();
  latch_write_arbiter_if #(.WIDTH(8)) bus1 ();

  assign bus0._req    = req_v[0];
  assign bus0._wdata0 = wd_v[0][0];
  assign bus0._wdata1 = wd_v[0][1];
  assign bus0._wdata2 = wd_v[0][2];
  assign bus0._wdata3 = wd_v[0][3];
  assign bus1._req    = req_v[1];
  assign bus1._wdata0 = wd_v[1][0];
  assign bus1._wdata1 = wd_v[1][1];
  assign bus1._wdata2 = wd_v[1][2];
  assign bus1._wdata3 = wd_v[1][3];

  latch_write_arbiter #(.WIDTH(8), .SETUP_CYC(1)) u_dut0 (
    ._clock (clk),
    ._reset (rst_n[0]),
    .bus    (bus0)
  );

  latch_write_arbiter #(.WIDTH(8), .SETUP_CYC(3)) u_dut1 (
    ._clock (clk),
    ._reset (rst_n[1]),
    .bus    (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: each transaction is a timeline counted in edges since
  // its grant edge (k=1 first setup cycle). With setup/hold length s:
  // setup k=1..s, enable k=s+1, hold k=s+2..2s+1 (ack at 2s+1), idle after.
  int         sc    [2] = '{1, 3};
  int         mk    [2];
  logic [1:0] mown  [2];
  logic [1:0] mptr  [2];
  logic [7:0] md    [2];
  logic [7:0] mret  [2];
  logic [3:0] req_s [2];
  logic [7:0] wd_s  [2][4];

  bit         drop_on_ack = 1'b1;
  logic [3:0] gq [$];
  logic [3:0] prev_gnt0 = 4'b0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int m);
    mk[m]   = 0;
    mown[m] = 2'd0;
    mptr[m] = 2'd0;
    md[m]   = 8'h00;
    mret[m] = 8'h00;
  endtask

  task automatic model_edge(input int m);
    int s;
    s = sc[m];
    if (mk[m] >= 1 && mk[m] <= 2 * s + 1) begin
      mk[m]++;
      if (mk[m] == s + 2) mret[m] = md[m];
      if (mk[m] == 2 * s + 2) mptr[m] = 2'((int'(mown[m]) + 1) % 4);
    end else if (req_s[m] != 4'b0000) begin
      for (int i = 0; i < 4; i++) begin
        automatic int j = (int'(mptr[m]) + i) % 4;
        if (req_s[m][j]) begin
          mown[m] = 2'(j);
          break;
        end
      end
      mk[m] = 1;
      md[m] = wd_s[m][mown[m]];
      $display("txn dut%0d t=%0t owner=%0d data=%02h", m, $time, mown[m], md[m]);
    end
  endtask

  task automatic check_dut(input int m);
    logic [3:0] g, a;
    logic [7:0] d, e, r;
    logic       b;
    bit         active;
    int         s;
    s = sc[m];
    if (m == 0) begin
      g = bus0._gnt; a = bus0._ack; d = bus0._D; e = bus0._E; b = bus0._busy; r = bus0._return;
    end else begin
      g = bus1._gnt; a = bus1._ack; d = bus1._D; e = bus1._E; b = bus1._busy; r = bus1._return;
    end
    active = (mk[m] >= 1 && mk[m] <= 2 * s + 1);
    chk($sformatf("d%0d_gnt", m), 32'(g), active ? 32'(4'b0001 << mown[m]) : 32'h0);
    chk($sformatf("d%0d_ack", m), 32'(a), (mk[m] == 2 * s + 1) ? 32'(4'b0001 << mown[m]) : 32'h0);
    chk($sformatf("d%0d_D", m), 32'(d), 32'(md[m]));
    chk($sformatf("d%0d_E", m), 32'(e), (mk[m] == s + 1) ? 32'hFF : 32'h0);
    chk($sformatf("d%0d_busy", m), 32'(b), 32'(active));
    chk($sformatf("d%0d_return", m), 32'(r), 32'(mret[m]));
  endtask

  // One clock: sample inputs, advance model at the edge, check 1 ns later.
  task automatic step();
    req_s = req_v;
    wd_s  = wd_v;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (!rst_n[m]) model_reset(m);
      else           model_edge(m);
    end
    #1;
    for (int m = 0; m < 2; m++) check_dut(m);
    if (bus0._gnt != 4'b0000 && prev_gnt0 == 4'b0000) gq.push_back(bus0._gnt);
    prev_gnt0 = bus0._gnt;
    if (drop_on_ack) begin
      for (int m = 0; m < 2; m++) begin
        if (mk[m] == 2 * sc[m] + 1) req_v[m][mown[m]] = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      rst_n[m] = 1'b0;
      req_v[m] = 4'b1111;
      for (int i = 0; i < 4; i++) wd_v[m][i] = 8'(8'h11 * (i + 1));
      model_reset(m);
    end

    // Reset held with all requests up: no grant, outputs zero.
    run(3);
    chk("rst_gnt", 32'(bus0._gnt), 32'h0);
    chk("rst_busy", 32'(bus0._busy), 32'h0);

    // Release; first edge grants requester 0. Then contention with drops on ack.
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    gq.delete();
    step();
    chk("rel_gnt0", 32'(bus0._gnt), 32'h1);
    chk("rel_D0", 32'(bus0._D), 32'h11);
    run(40);
    chk("cont_cnt", 32'(gq.size()), 32'd4);
    chk("cont_g0", 32'(gq[0]), 32'h1);
    chk("cont_g1", 32'(gq[1]), 32'h2);
    chk("cont_g2", 32'(gq[2]), 32'h4);
    chk("cont_g3", 32'(gq[3]), 32'h8);
    chk("cont_ret0", 32'(bus0._return), 32'h44);
    chk("cont_ret1", 32'(bus1._return), 32'h44);

    // Single write of A5 from requester 2.
    req_v[0]   = 4'b0100;
    wd_v[0][2] = 8'hA5;
    step();
    chk("sw_gnt", 32'(bus0._gnt), 32'h4);
    chk("sw_D", 32'(bus0._D), 32'hA5);
    chk("sw_E1", 32'(bus0._E), 32'h0);
    step();
    chk("sw_E2", 32'(bus0._E), 32'hFF);
    chk("sw_ret2", 32'(bus0._return), 32'h44);
    step();
    chk("sw_ack", 32'(bus0._ack), 32'h4);
    chk("sw_ret3", 32'(bus0._return), 32'hA5);
    chk("sw_E3", 32'(bus0._E), 32'h0);
    step();
    chk("sw_busy", 32'(bus0._busy), 32'h0);
    run(4);

    // Fairness: 0 and 1 hold their requests continuously.
    drop_on_ack = 1'b0;
    req_v[0] = 4'b0011;
    req_v[1] = 4'b0011;
    gq.delete();
    run(24);
    chk("fair_cnt", 32'(gq.size()), 32'd6);
    chk("fair_g0", 32'(gq[0]), 32'h1);
    chk("fair_g1", 32'(gq[1]), 32'h2);
    chk("fair_g2", 32'(gq[2]), 32'h1);
    chk("fair_g3", 32'(gq[3]), 32'h2);
    req_v[0] = 4'b0000;
    req_v[1] = 4'b0000;
    drop_on_ack = 1'b1;
    run(10);

    // Data and request changes after the grant are ignored.
    req_v[0]   = 4'b0010;
    wd_v[0][1] = 8'h11;
    step();
    chk("ign_D1", 32'(bus0._D), 32'h11);
    wd_v[0][1] = 8'h22;
    step();
    chk("ign_E", 32'(bus0._E), 32'hFF);
    chk("ign_D2", 32'(bus0._D), 32'h11);
    req_v[0][1] = 1'b0;
    step();
    chk("ign_ack", 32'(bus0._ack), 32'h2);
    chk("ign_ret", 32'(bus0._return), 32'h11);
    step();
    chk("ign_idleD", 32'(bus0._D), 32'h11);

    // Reset during ENABLE, 1-cycle instance.
    req_v[0]   = 4'b1000;
    wd_v[0][3] = 8'h5A;
    step();
    step();
    chk("mr0_E_on", 32'(bus0._E), 32'hFF);
    rst_n[0] = 1'b0;
    #1;
    model_reset(0);
    chk("mr0_E_off", 32'(bus0._E), 32'h0);
    chk("mr0_ack", 32'(bus0._ack), 32'h0);
    chk("mr0_ret", 32'(bus0._return), 32'h0);
    chk("mr0_gnt", 32'(bus0._gnt), 32'h0);
    step();
    rst_n[0] = 1'b1;
    req_v[0] = 4'b1010;
    step();
    chk("mr0_ptr", 32'(bus0._gnt), 32'h2);
    run(12);
    req_v[0] = 4'b0000;

    // Same on the 3-cycle instance, checking setup/enable/hold lengths.
    req_v[1]   = 4'b1000;
    wd_v[1][3] = 8'hC3;
    step();
    chk("mr1_gnt", 32'(bus1._gnt), 32'h8);
    chk("mr1_D", 32'(bus1._D), 32'hC3);
    step();
    step();
    chk("mr1_E_k3", 32'(bus1._E), 32'h0);
    step();
    chk("mr1_E_k4", 32'(bus1._E), 32'hFF);
    rst_n[1] = 1'b0;
    #1;
    model_reset(1);
    chk("mr1_E_off", 32'(bus1._E), 32'h0);
    chk("mr1_ack", 32'(bus1._ack), 32'h0);
    chk("mr1_ret", 32'(bus1._return), 32'h0);
    step();
    rst_n[1] = 1'b1;
    req_v[1] = 4'b1010;
    step();
    chk("mr1_ptr", 32'(bus1._gnt), 32'h2);
    for (int k = 2; k <= 8; k++) begin
      step();
      chk($sformatf("s3_E_k%0d", k), 32'(bus1._E), (k == 4) ? 32'hFF : 32'h0);
      chk($sformatf("s3_ack_k%0d", k), 32'(bus1._ack), (k == 7) ? 32'h2 : 32'h0);
      chk($sformatf("s3_busy_k%0d", k), 32'(bus1._busy), (k == 8) ? 32'h0 : 32'h1);
    end
    run(20);
    req_v[1] = 4'b0000;
    run(10);

    // Random protocol-respecting traffic with occasional asynchronous resets.
    for (int n = 0; n < 400; n++) begin
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 3) == 0) req_v[m] = req_v[m] | 4'($urandom_range(0, 15));
        for (int i = 0; i < 4; i++) wd_v[m][i] = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 149) == 0) begin
        automatic int m = int'($urandom_range(0, 1));
        rst_n[m] = 1'b0;
        #1;
        model_reset(m);
        check_dut(m);
        step();
        rst_n[m] = 1'b1;
      end else begin
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
